// File: rtl/dma_arbiter.sv
// dma_arbiter
//
// Shares the device-side port (port B) of the dual-port system RAM between
// NREQ memory-mapped devices such as the monitor, keyboard, clock and floppy.
// Transfers are single words, one at a time. The next owner is picked by
// round-robin. A requester may hold a short locked burst, capped at LOCK_MAX
// consecutive grants, so the other requesters are never starved.
//
// Transfer timeline (c0 = the IDLE cycle in which the request is seen):
//   c0        IDLE : pick the winner and register its addr/wdata/wr.
//   c1        ISSUE: the RAM samples the port at the end of c1.
//   c2..      WAIT : reads only, RD_LATENCY cycles. DMA_q is captured on the
//                    last WAIT edge.
//   c2 / c2+L ACK  : a one-cycle REQ_ack pulse. GRANT clears at the next edge.
//
// Ports:
//   DMA_CLOCK   in   sole clock
//   RESET       in   synchronous, active-high reset
//   REQ_req     in   [NREQ]     per-requester request, held until ack
//   REQ_wr      in   [NREQ]     1 = write, 0 = read
//   REQ_lock    in   [NREQ]     ask to keep the grant for the next transfer
//   REQ_addr    in   [16*NREQ]  packed word addresses, slice i = requester i
//   REQ_wdata   in   [16*NREQ]  packed write data
//   REQ_ack     out  [NREQ]     one-cycle completion pulse
//   REQ_rdata   out  [16]       read data, valid in the ack cycle
//   GRANT       out  [NREQ]     one-hot owner of the current transfer
//   DMA_addr    out  [16]       RAM port B address
//   DMA_data    out  [16]       RAM port B write data
//   DMA_wren    out  1          RAM port B write enable
//   DMA_q       in   [16]       RAM port B read data

module dma_arbiter #(
    parameter int NREQ       = 4,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 16
) (
    input  logic                 DMA_CLOCK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ_req,
    input  logic [NREQ-1:0]      REQ_wr,
    input  logic [NREQ-1:0]      REQ_lock,
    input  logic [16*NREQ-1:0]   REQ_addr,
    input  logic [16*NREQ-1:0]   REQ_wdata,
    output logic [NREQ-1:0]      REQ_ack,
    output logic [15:0]          REQ_rdata,
    output logic [NREQ-1:0]      GRANT,
    output logic [15:0]          DMA_addr,
    output logic [15:0]          DMA_data,
    output logic                 DMA_wren,
    input  logic [15:0]          DMA_q
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCW = $clog2(RD_LATENCY + 1);
    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [IW-1:0]   last_q,      last_d;       // most recent owner
    logic            owner_vld_q, owner_vld_d;  // a grant has happened since reset
    logic [LCW-1:0]  lock_cnt_q,  lock_cnt_d;   // consecutive locked regrants
    logic [WCW-1:0]  wait_cnt_q,  wait_cnt_d;   // read-latency countdown

    logic [NREQ-1:0] grant_d;
    logic [NREQ-1:0] ack_d;
    logic [15:0]     rdata_d;
    logic [15:0]     addr_d;
    logic [15:0]     data_d;
    logic            wren_d;

    logic [IW-1:0]   cand;
    logic [IW-1:0]   rr_idx;
    logic            rr_found;
    logic            lock_hit;
    logic [IW-1:0]   win_idx;

    // Round-robin search: the first set request bit found by walking
    // cyclically from last+1. The walk ends back at last itself, so a lone
    // requester can win again.
    // NOTE: every variable written in an always_comb gets a value at the top
    // of the block; a path that skipped one would infer a latch.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        cand     = last_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!rr_found && REQ_req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // The previous owner keeps the port while it still requests with lock
    // set, until the burst cap is reached. After the cap it falls back to
    // round-robin from last+1, which sends it to the back of the queue.
    assign lock_hit = owner_vld_q && REQ_req[last_q] && REQ_lock[last_q] &&
                      (int'(lock_cnt_q) < LOCK_MAX - 1);
    assign win_idx  = lock_hit ? last_q : rr_idx;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_vld_d = owner_vld_q;
        lock_cnt_d  = lock_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        grant_d     = GRANT;
        ack_d       = '0;
        rdata_d     = REQ_rdata;
        addr_d      = DMA_addr;
        data_d      = DMA_data;
        wren_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|REQ_req) begin
                    // addr/wdata/wr are taken only here. Later changes by the
                    // requester do not affect the transfer in flight.
                    grant_d     = NREQ'(1) << win_idx;
                    addr_d      = REQ_addr[16*win_idx +: 16];
                    data_d      = REQ_wdata[16*win_idx +: 16];
                    wren_d      = REQ_wr[win_idx];
                    last_d      = win_idx;
                    owner_vld_d = 1'b1;
                    lock_cnt_d  = lock_hit ? LCW'(lock_cnt_q + LCW'(1)) : '0;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                // The RAM samples the port at the end of this cycle. The
                // registered DMA_wren still tells this state whether the
                // transfer is a write.
                if (DMA_wren) begin
                    ack_d   = GRANT;
                    state_d = ACK;
                end else begin
                    wait_cnt_d = WCW'(RD_LATENCY);
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_q - WCW'(1);
                if (wait_cnt_q == WCW'(1)) begin
                    rdata_d = DMA_q;
                    ack_d   = GRANT;
                    state_d = ACK;
                end
            end

            ACK: begin
                grant_d = '0;
                state_d = IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every register then
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge DMA_CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            owner_vld_q <= 1'b0;
            lock_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            GRANT       <= '0;
            REQ_ack     <= '0;
            REQ_rdata   <= '0;
            DMA_addr    <= '0;
            DMA_data    <= '0;
            DMA_wren    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_vld_q <= owner_vld_d;
            lock_cnt_q  <= lock_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            GRANT       <= grant_d;
            REQ_ack     <= ack_d;
            REQ_rdata   <= rdata_d;
            DMA_addr    <= addr_d;
            DMA_data    <= data_d;
            DMA_wren    <= wren_d;
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Testbench for dma_arbiter: a table of single-cycle vectors, directed
// multi-cycle sequences, and a randomized run against a transaction-level
// reference model.

module tb_dma_arbiter;

    localparam int NREQ       = 4;
    localparam int RD_LATENCY = 1;
    localparam int LOCK_MAX   = 4;

    logic                 DMA_CLOCK = 1'b0;
    logic                 RESET;
    logic [NREQ-1:0]      REQ_req, REQ_wr, REQ_lock;
    logic [16*NREQ-1:0]   REQ_addr, REQ_wdata;
    logic [NREQ-1:0]      REQ_ack, GRANT;
    logic [15:0]          REQ_rdata, DMA_addr, DMA_data, DMA_q;
    logic                 DMA_wren;

    int n_checks = 0;
    int n_pass   = 0;

    dma_arbiter #(
        .NREQ       (NREQ),
        .RD_LATENCY (RD_LATENCY),
        .LOCK_MAX   (LOCK_MAX)
    ) dut (
        .DMA_CLOCK (DMA_CLOCK),
        .RESET     (RESET),
        .REQ_req   (REQ_req),
        .REQ_wr    (REQ_wr),
        .REQ_lock  (REQ_lock),
        .REQ_addr  (REQ_addr),
        .REQ_wdata (REQ_wdata),
        .REQ_ack   (REQ_ack),
        .REQ_rdata (REQ_rdata),
        .GRANT     (GRANT),
        .DMA_addr  (DMA_addr),
        .DMA_data  (DMA_data),
        .DMA_wren  (DMA_wren),
        .DMA_q     (DMA_q)
    );

    always #5 DMA_CLOCK = ~DMA_CLOCK;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // RAM port B model with a read latency of 1. Locations never written
    // read back as init_val(addr).
    logic [15:0] ram    [0:65535];
    bit          ram_wr [0:65535];
    always @(posedge DMA_CLOCK) begin
        if (DMA_wren) begin
            ram[DMA_addr]    <= DMA_data;
            ram_wr[DMA_addr] <= 1'b1;
        end
        DMA_q <= ram_wr[DMA_addr] ? ram[DMA_addr] : init_val(DMA_addr);
    end

    // Shadow memory for the reference model.
    logic [15:0] mmem [0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge DMA_CLOCK);
        #1;
    endtask

    task automatic set_slices(input logic [15:0] abase, input logic [15:0] dbase);
        for (int i = 0; i < NREQ; i++) begin
            REQ_addr[16*i +: 16]  = abase + 16'(i * 256);
            REQ_wdata[16*i +: 16] = dbase + 16'(i);
        end
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        REQ_req  = '0;
        REQ_wr   = '0;
        REQ_lock = '0;
        set_slices(16'h4000, 16'hA000);
        tick();
        RESET = 1'b0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  req, wr, lock;
        logic [15:0] addr, wdata;
        logic [3:0]  e_grant, e_ack;
        logic        e_wren;
        logic [15:0] e_data;
        logic        chk_ad;
        logic [15:0] e_addr;
        logic        chk_rd;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vt [10];

    task automatic run_table();
        vt[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vt[1] = '{1'b0, 4'h1, 4'h1, 4'h0, 16'h8000, 16'hBEEF, 4'h1, 4'h0, 1'b1, 16'hBEEF, 1'b1, 16'h8000, 1'b0, 16'h0000};
        vt[2] = '{1'b0, 4'h1, 4'h1, 4'h0, 16'h8000, 16'hBEEF, 4'h1, 4'h1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[3] = '{1'b0, 4'h1, 4'h1, 4'h0, 16'h8000, 16'hBEEF, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[4] = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h8000, 16'hBEEF, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[5] = '{1'b0, 4'h4, 4'h0, 4'h0, 16'h7E00, 16'h0000, 4'h4, 4'h0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'h0000};
        vt[6] = '{1'b0, 4'h4, 4'h0, 4'h0, 16'h7E00, 16'h0000, 4'h4, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[7] = '{1'b0, 4'h4, 4'h0, 4'h0, 16'h7E00, 16'h0000, 4'h4, 4'h4, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
        vt[8] = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h7E00, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[9] = '{1'b0, 4'h0, 4'h0, 4'h0, 16'h7E00, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        for (int k = 0; k < 10; k++) begin
            RESET    = vt[k].rst;
            REQ_req  = vt[k].req;
            REQ_wr   = vt[k].wr;
            REQ_lock = vt[k].lock;
            set_slices(vt[k].addr, vt[k].wdata);
            tick();
            check($sformatf("vec%0d_grant", k), 32'(GRANT), 32'(vt[k].e_grant));
            check($sformatf("vec%0d_ack", k), 32'(REQ_ack), 32'(vt[k].e_ack));
            check($sformatf("vec%0d_wren", k), 32'(DMA_wren), 32'(vt[k].e_wren));
            if (vt[k].e_wren) check($sformatf("vec%0d_data", k), 32'(DMA_data), 32'(vt[k].e_data));
            if (vt[k].chk_ad) check($sformatf("vec%0d_addr", k), 32'(DMA_addr), 32'(vt[k].e_addr));
            if (vt[k].chk_rd) check($sformatf("vec%0d_rdata", k), 32'(REQ_rdata), 32'(vt[k].e_rdata));
        end
    endtask

    // Collect six acks under a cycle budget and compare the owners with the
    // expected order. Back-to-back writes must complete every 3 cycles.
    task automatic collect_order(input string name, input int exp_ord [6]);
        int got    = 0;
        int last_c = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            tick();
            if (REQ_ack != '0) begin
                check($sformatf("%s_ack%0d", name, got), 32'(REQ_ack), 32'(1) << exp_ord[got]);
                if (got > 0) check($sformatf("%s_spacing%0d", name, got), 32'(c - last_c), 32'd3);
                last_c = c;
                got++;
                if (got == 6) REQ_req = '0;
            end
        end
        check({name, "_count"}, 32'(got), 32'd6);
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic directed();
        int rr_ord   [6] = '{0, 1, 2, 3, 0, 1};
        int lock_ord [6] = '{1, 1, 1, 1, 3, 1};

        // All four requesters write continuously without lock.
        do_reset();
        REQ_req = 4'hF;
        REQ_wr  = 4'hF;
        collect_order("rr", rr_ord);

        // Requester 1 locks; requester 3 must get in after LOCK_MAX grants.
        do_reset();
        REQ_req  = 4'b1010;
        REQ_wr   = 4'hF;
        REQ_lock = 4'b0010;
        collect_order("lock", lock_ord);

        // RESET asserted during the WAIT of a read.
        do_reset();
        set_slices(16'h1034, 16'h0000);
        REQ_req = 4'b0100;
        tick();
        check("rstw_issue_grant", 32'(GRANT), 32'h4);
        tick();
        check("rstw_wait_ack", 32'(REQ_ack), 32'h0);
        RESET   = 1'b1;
        REQ_req = '0;
        tick();
        check("rstw_grant", 32'(GRANT), 32'h0);
        check("rstw_ack", 32'(REQ_ack), 32'h0);
        check("rstw_wren", 32'(DMA_wren), 32'h0);
        RESET = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("rstw_quiet_ack%0d", c), 32'(REQ_ack), 32'h0);
            check($sformatf("rstw_quiet_grant%0d", c), 32'(GRANT), 32'h0);
        end
        set_slices(16'h0042, 16'h1111);
        REQ_req = 4'b0001;
        REQ_wr  = 4'b0001;
        tick();
        check("rstw_next_grant", 32'(GRANT), 32'h1);
        check("rstw_next_wren", 32'(DMA_wren), 32'h1);
        check("rstw_next_addr", 32'(DMA_addr), 32'h0042);
        tick();
        check("rstw_next_ack", 32'(REQ_ack), 32'h1);
        REQ_req = '0;
        tick();
        check("rstw_next_done", 32'(GRANT), 32'h0);

        // Requester 0 drops req during ISSUE.
        do_reset();
        set_slices(16'h00AA, 16'h5555);
        REQ_req = 4'b0001;
        REQ_wr  = 4'b0001;
        tick();
        check("drop_issue_grant", 32'(GRANT), 32'h1);
        REQ_req = '0;
        tick();
        check("drop_ack", 32'(REQ_ack), 32'h1);
        check("drop_ack_grant", 32'(GRANT), 32'h1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("drop_idle_grant%0d", c), 32'(GRANT), 32'h0);
            check($sformatf("drop_idle_ack%0d", c), 32'(REQ_ack), 32'h0);
        end
    endtask

    // ---------------- randomized run with reference model ----------------
    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = a + 16'hFFF8;
        return a;
    endfunction

    task automatic random_test(input int cycles);
        logic        pend    [NREQ];
        logic        r_wr    [NREQ];
        logic        r_lock  [NREQ];
        logic [15:0] r_addr  [NREQ];
        logic [15:0] r_wdata [NREQ];
        int          m_last, m_run, g_start, t_ack, idle_from, g_who, w;
        bit          m_vld, any;
        logic        g_wr;
        logic [15:0] g_addr, g_data, g_rd;
        logic [NREQ-1:0] e_grant, e_ack;
        logic        e_wren;

        m_last = NREQ - 1; m_run = 0; m_vld = 1'b0;
        g_start = -10; t_ack = -10; idle_from = 0; g_who = 0;
        g_wr = 1'b0; g_addr = '0; g_data = '0; g_rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; r_wr[i] = 1'b0; r_lock[i] = 1'b0;
            r_addr[i] = '0; r_wdata[i] = '0;
        end
        do_reset();

        for (int t = 0; t < cycles; t++) begin
            e_grant = (t >= g_start && t <= t_ack) ? NREQ'(1) << g_who : '0;
            e_ack   = (t == t_ack) ? NREQ'(1) << g_who : '0;
            e_wren  = (t == g_start) ? g_wr : 1'b0;
            check("rnd_grant", 32'(GRANT), 32'(e_grant));
            check("rnd_ack", 32'(REQ_ack), 32'(e_ack));
            check("rnd_wren", 32'(DMA_wren), 32'(e_wren));
            if (t == g_start) begin
                check("rnd_addr", 32'(DMA_addr), 32'(g_addr));
                if (g_wr) check("rnd_data", 32'(DMA_data), 32'(g_data));
            end
            if (t == t_ack && !g_wr) check("rnd_rdata", 32'(REQ_rdata), 32'(g_rd));

            // Requesters: hold until ack, then maybe queue another transfer.
            for (int i = 0; i < NREQ; i++) begin
                logic fresh;
                fresh = 1'b0;
                if (t == t_ack && i == g_who) begin
                    pend[i] = ($urandom_range(0, 2) != 0);
                    fresh   = pend[i];
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    fresh   = 1'b1;
                end
                if (fresh) begin
                    r_wr[i]    = 1'($urandom_range(0, 1));
                    r_lock[i]  = ($urandom_range(0, 2) == 0);
                    r_addr[i]  = rand_addr();
                    r_wdata[i] = 16'($urandom);
                end
                REQ_req[i]            = pend[i];
                REQ_wr[i]             = r_wr[i];
                REQ_lock[i]           = r_lock[i];
                REQ_addr[16*i +: 16]  = r_addr[i];
                REQ_wdata[16*i +: 16] = r_wdata[i];
            end

            // Model: when the port is free, decide the next owner from the
            // lock rule or the round-robin rule.
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (pend[i]) any = 1'b1;
            if (t >= idle_from && any) begin
                w = -1;
                if (m_vld && pend[m_last] && r_lock[m_last] && m_run < LOCK_MAX - 1) begin
                    w = m_last;
                    m_run++;
                end else begin
                    for (int off = 1; off <= NREQ; off++)
                        if (w < 0 && pend[(m_last + off) % NREQ]) w = (m_last + off) % NREQ;
                    m_run = 0;
                end
                g_who     = w;
                m_last    = w;
                m_vld     = 1'b1;
                g_wr      = r_wr[w];
                g_addr    = r_addr[w];
                g_data    = r_wdata[w];
                g_start   = t + 1;
                t_ack     = t + (g_wr ? 2 : 2 + RD_LATENCY);
                idle_from = t_ack + 1;
                if (g_wr) mmem[g_addr] = g_data;
                else      g_rd = mmem[g_addr];
            end
            tick();
        end
        REQ_req = '0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mmem[a] = init_val(16'(a));
        RESET     = 1'b1;
        REQ_req   = '0;
        REQ_wr    = '0;
        REQ_lock  = '0;
        REQ_addr  = '0;
        REQ_wdata = '0;
        run_table();
        directed();
        random_test(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
